// File: rtl/uzorak_loader_pkg.sv
// Shared ANN constants: feature count, feature word width and loader state encoding.
// Neuron modules and the sample loader both import this package.
package uzorak_loader_pkg;

  localparam int BROJ_ZNACAJKI = 60;
  localparam int SIRINA        = 16;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage : uzorak_loader_pkg

// File: rtl/uzorak_loader.sv
// Serial-to-parallel sample loader: packs BROJ_ZNACAJKI feature words into one wide
// vector for the hidden layer and holds it until the layer takes it.
//
// Handshakes: a word moves on the input side when in_valid && in_ready at a rising
// edge; a sample moves on the output side when uzorak_valid && uzorak_ready at a
// rising edge. Neither valid depends combinationally on its matching ready.
module uzorak_loader #(
  parameter int BROJ_ZNACAJKI = uzorak_loader_pkg::BROJ_ZNACAJKI,
  parameter int SIRINA        = uzorak_loader_pkg::SIRINA
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [SIRINA-1:0]                 in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [BROJ_ZNACAJKI*SIRINA-1:0]   uzorak,
  output logic                              uzorak_valid,
  input  logic                              uzorak_ready,
  output logic                              frame_err,
  output logic                              dbg_state
);
  import uzorak_loader_pkg::*;

  localparam int CNT_W = (BROJ_ZNACAJKI > 1) ? $clog2(BROJ_ZNACAJKI) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BROJ_ZNACAJKI - 1);

  state_t                            r_state;
  logic [CNT_W-1:0]                  r_cnt;
  logic [BROJ_ZNACAJKI*SIRINA-1:0]   r_uzorak;
  logic                              r_frame_err;

  state_t                            w_state_nxt;
  logic [CNT_W-1:0]                  w_cnt_nxt;
  logic                              w_err_nxt;
  logic                              w_accept;
  logic                              w_last_slot;

  assign w_accept    = in_valid && (r_state == LOAD);
  assign w_last_slot = (r_cnt == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_accept) begin
          if (w_last_slot && in_last) begin
            w_state_nxt = FULL;
            w_cnt_nxt   = '0;
          end else if (w_last_slot || in_last) begin
            // Short or long frame: drop what was collected and resync on the next word.
            w_err_nxt = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      FULL: begin
        if (uzorak_ready) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_frame_err <= w_err_nxt;
    end
  end

  // Words land in their slot untouched; slots beyond cnt keep the previous sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uzorak <= '0;
    end else if (w_accept) begin
      r_uzorak[int'(r_cnt)*SIRINA +: SIRINA] <= in_data;
    end
  end

  assign in_ready     = (r_state == LOAD);
  assign uzorak_valid = (r_state == FULL);
  assign uzorak       = r_uzorak;
  assign frame_err    = r_frame_err;
  assign dbg_state    = r_state;

endmodule : uzorak_loader

// File: tb/tb_uzorak_loader.sv
// Bench for uzorak_loader: directed scenarios plus randomized stalls and data,
// checked cycle by cycle against a slot/queue model of the sample framing rules.
module tb_uzorak_loader;

  localparam int N  = uzorak_loader_pkg::BROJ_ZNACAJKI;
  localparam int W  = uzorak_loader_pkg::SIRINA;
  localparam int TW = N * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [TW-1:0] uzorak;
  logic          uzorak_valid;
  logic          uzorak_ready = 1'b0;
  logic          frame_err;
  logic          dbg_state;

  uzorak_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .uzorak       (uzorak),
    .uzorak_valid (uzorak_valid),
    .uzorak_ready (uzorak_ready),
    .frame_err    (frame_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [TW-1:0] exp_q[$];      // completed samples awaiting handoff
  logic [TW-1:0] m_vec;         // slot contents as the source has written them
  int            m_cnt;
  bit            m_full;
  bit            m_err;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_vec  = '0;
    m_cnt  = 0;
    m_full = 0;
    m_err  = 0;
  endtask

  task automatic model_accept(input logic [W-1:0] d, input logic last);
    m_vec[m_cnt*W +: W] = d;
    if (m_cnt == N - 1 && last) begin
      exp_q.push_back(m_vec);
      m_full = 1;
      m_cnt  = 0;
    end else if (m_cnt == N - 1 || last) begin
      m_err = 1;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // One clock: capture what the DUT sees at the edge, advance the model, compare.
  task automatic tick();
    logic v, l, r;
    logic [W-1:0] d;
    v = in_valid; l = in_last; r = uzorak_ready; d = in_data;
    @(posedge clk);
    #1;
    m_err = 0;
    if (m_full) begin
      if (r) begin
        m_full = 0;
        m_cnt  = 0;
        void'(exp_q.pop_front());
      end
    end else if (v) begin
      model_accept(d, l);
    end
    check("in_ready", TW'(in_ready), TW'(!m_full));
    check("uzorak_valid", TW'(uzorak_valid), TW'(m_full));
    check("frame_err", TW'(frame_err), TW'(m_err));
    if (m_full && exp_q.size() > 0) check("uzorak", uzorak, exp_q[0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] base, input int len, input int last_idx);
    for (int k = 0; k < len; k++) send_word(W'(base + W'(k)), k == last_idx);
  endtask

  task automatic handoff(input int delay);
    repeat (delay) tick();
    uzorak_ready = 1'b1;
    tick();
    uzorak_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, TW'(in_ready), TW'(1));
    check({tag, "_valid"}, TW'(uzorak_valid), TW'(0));
    check({tag, "_frame_err"}, TW'(frame_err), TW'(0));
    check({tag, "_uzorak"}, uzorak, '0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #12;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Sample 1: data k+1, last on word 59.
    send_frame(W'(1), N, N - 1);
    check("s1_valid", TW'(uzorak_valid), TW'(1));
    check("s1_feat0", TW'(uzorak[W-1:0]), TW'(1));
    check("s1_feat59", TW'(uzorak[TW-1 -: W]), TW'(N));

    // Hold with the source pushing, then hand off.
    in_data  = 16'hdead;
    in_valid = 1'b1;
    repeat (10) tick();
    uzorak_ready = 1'b1;
    tick();
    uzorak_ready = 1'b0;
    in_valid     = 1'b0;
    check("handoff_ready", TW'(in_ready), TW'(1));

    // uzorak_ready while loading is meaningless.
    uzorak_ready = 1'b1;
    repeat (3) tick();
    uzorak_ready = 1'b0;

    // Short sample, then a full one that must start at slot 0.
    send_frame(16'h0200, 31, 30);
    tick();
    send_frame(16'h0300, N, N - 1);
    check("post_short_feat0", TW'(uzorak[W-1:0]), TW'(16'h0300));
    handoff(2);

    // Long sample: no last on word 59.
    send_frame(16'h0400, N, -1);
    send_frame(16'h0500, N, N - 1);
    check("post_long_feat0", TW'(uzorak[W-1:0]), TW'(16'h0500));
    handoff(0);

    // Source stalls (~50% gaps) on a negative sign-magnitude sample.
    begin
      int k;
      int budget;
      k = 0;
      budget = 0;
      while (!m_full && budget < 1000) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = W'(16'h8123 + W'(k));
        in_last  = (k == N - 1);
        tick();
        if (in_valid) k++;
        budget++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("stall_accepts", TW'(k), TW'(N));
      check("stall_feat59", TW'(uzorak[TW-1 -: W]), TW'(16'h8123 + N - 1));
    end
    handoff(3);

    // Reset mid-sample (after 25 words) and while holding a full sample.
    send_frame(16'h0600, 25, -1);
    async_reset("rst_mid");
    send_frame(16'h0700, N, N - 1);
    check("post_rst_mid_feat0", TW'(uzorak[W-1:0]), TW'(16'h0700));
    async_reset("rst_full");
    tick();
    send_frame(16'h0800, N, N - 1);
    check("post_rst_full_feat0", TW'(uzorak[W-1:0]), TW'(16'h0800));
    handoff(1);

    // Random data, random framing errors, random stalls and handoff delays.
    for (int s = 0; s < 6; s++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N + 5)) : N;
      for (int k = 0; k < len; k++) begin
        while ($urandom_range(0, 3) == 0) tick();
        send_word(W'($urandom), (k == len - 1) && (len <= N));
        if (m_err) break;
      end
      if (m_full) handoff(int'($urandom_range(0, 4)));
    end
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Watchdog keeps the run finite even if the stimulus stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "timeout");
  end

endmodule : tb_uzorak_loader

// File: doc/uzorak_loader.md
UZORAK_LOADER -- requirements
Module: uzorak_loader

Interface
REQ-001 Parameter BROJ_ZNACAJKI, default 60: number of features per sample.
REQ-002 Parameter SIRINA, default 16: width of one feature word, in sign-magnitude fixed point.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port in_data, input, SIRINA bits: one feature word from the serial source.
REQ-006 Port in_valid, input, 1 bit: in_data and in_last are valid this cycle.
REQ-007 Port in_last, input, 1 bit: marks the final feature of a sample.
REQ-008 Port in_ready, output, 1 bit: loader accepts a word this cycle.
REQ-009 Port uzorak, output, BROJ_ZNACAJKI*SIRINA bits: assembled sample vector for the neuron layer.
REQ-010 Port uzorak_valid, output, 1 bit: uzorak holds a complete sample.
REQ-011 Port uzorak_ready, input, 1 bit: the downstream layer accepts uzorak this cycle.
REQ-012 Port frame_err, output, 1 bit: one-cycle pulse when a malformed sample is discarded.

Function
REQ-013 The loader SHALL have two states: LOAD, which collects words, and FULL, which holds a complete sample.
REQ-014 A word is accepted when in_valid and in_ready are both high at a clock edge.
REQ-015 In LOAD, in_ready SHALL be 1 and uzorak_valid SHALL be 0; in FULL, in_ready SHALL be 0 and uzorak_valid SHALL be 1.
REQ-016 The accepted word with index k (0-based, counted by an internal counter cnt) SHALL be written unmodified to uzorak[16k+15:16k], so feature 0 lands at bits [15:0].
REQ-017 cnt SHALL be wide enough for BROJ_ZNACAJKI-1 (6 bits by default), SHALL increment on each accepted word, and SHALL return to 0 at the end of each sample or on an error.
REQ-018 If the accepted word has cnt == BROJ_ZNACAJKI-1 and in_last == 1, the state SHALL become FULL and uzorak_valid SHALL rise on the next cycle; the latency from the last accepted word to uzorak_valid is 1 cycle.
REQ-019 If in_last == 1 with cnt < BROJ_ZNACAJKI-1 (short sample), or in_last == 0 with cnt == BROJ_ZNACAJKI-1 (long sample), the loader SHALL:
- assert frame_err for exactly one cycle after the edge;
- set cnt to 0 and remain in LOAD;
- not raise uzorak_valid.
REQ-020 In FULL, uzorak SHALL remain bit-stable until a handoff; in_valid SHALL be ignored in this state.
REQ-021 When uzorak_valid and uzorak_ready are both high at an edge (handoff), the state SHALL become LOAD and cnt SHALL become 0; in_ready rises in the following cycle, so there is a 1-cycle bubble.
REQ-022 uzorak_ready while in LOAD SHALL have no effect.
REQ-023 During LOAD, slots not yet overwritten SHALL keep the previous sample's values; uzorak is meaningful only while uzorak_valid is high.
REQ-024 The block SHALL NOT perform any arithmetic; sign-magnitude words pass through unaltered.

Reset
REQ-025 While rst_n == 0, asynchronously:
- state = LOAD, cnt = 0;
- uzorak = 0, uzorak_valid = 0, frame_err = 0, in_ready = 1 (registered, or derived from the state).
REQ-026 Reset during a partial sample or in FULL SHALL discard the sample with no frame_err pulse.
REQ-027 The first word accepted after rst_n rises SHALL be treated as feature 0.

Structure
REQ-028 BROJ_ZNACAJKI, SIRINA, and the state encoding (LOAD = 0, FULL = 1) SHALL live in the shared ANN constants package used by the neuron modules.
REQ-029 The loader SHALL be a single module with no sub-modules; its uzorak output connects directly to the uzorak input of every hidden-layer neuron.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Sample 1: 60 back-to-back words with in_data = k+1 and in_last on word 59 -> uzorak_valid = 1 the cycle after word 59; uzorak[15:0] = 1 and uzorak[959:944] = 60.
- Hold then handoff: hold uzorak_ready = 0 for 10 cycles while driving in_valid = 1 -> in_ready = 0 and uzorak unchanged; then pulse uzorak_ready -> next cycle uzorak_valid = 0 and in_ready = 1.
- Short sample: in_last on word 30 -> frame_err pulse of 1 cycle and no uzorak_valid; then a full 60-word sample -> valid sample with feature 0 = the first word sent after the error.
- Long sample: in_last = 0 on word 59 -> frame_err pulse; cnt restarts at 0.
- Source stalls: random in_valid gaps (about 50%) over a sample of 0x8123 words -> identical packing and valid after exactly 60 accepts.
- Reset: assert rst_n = 0 mid-sample at word 25 and again while in FULL -> all outputs reach reset values immediately, no frame_err pulse, and the next sample packs from slot 0.
